// File: rtl/pe_op_sequencer.sv
// ---------------------------------------------------------------------------
// pe_op_sequencer
//
// Control stage that sits directly upstream of the 16-bit PE array. It takes
// one instruction at a time over a valid/ready handshake and turns it into a
// cycle-exact sequence of PE control signals: RAM addresses, write enables,
// ALU select, the bit-serial step count and the E/W/S/N shift strobes.
//
// Instruction kinds:
//   0 = ALU   : ALU_RUN for ALU_CYCLES steps, one ALU_WB write-back, DONE
//   1 = SHIFT : SH_RD (synchronous RAM read), SH_WR (write + strobe), DONE
//   2/3 = NOP : straight to DONE
//
// Every output is a flop. The combinational block works out the next state
// and the output values that belong to that next state, so the outputs
// change on the same edge as the state.
//
// Optional feature (macro OP_EARLY_EXIT_EN):
//   When defined, an asserted i_op_all (AND of all PE Op flags) in ALU_RUN
//   with count >= 2 cuts the ALU phase short. The count freezes and a sticky
//   early-exit flag is raised on o_early_exit. When undefined, i_op_all and
//   o_early_exit do not exist and the ALU phase always runs in full.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_reset         asynchronous reset, active low
//   i_ins_valid     instruction presented
//   o_ins_ready     instruction accepted this cycle (high only in IDLE)
//   i_ins_kind      0=ALU, 1=SHIFT, 2/3=NOP
//   i_ins_alu_sel   ALU operation code
//   i_ins_dir       shift direction: 0=east, 1=west, 2=south, 3=north
//   i_ins_src_a     port-A source address
//   i_ins_src_b     port-B source address
//   i_ins_dst       destination address
//   i_op_all        AND of all PE Op outputs        (OP_EARLY_EXIT_EN only)
//   o_early_exit    sticky early-exit flag          (OP_EARLY_EXIT_EN only)
//   o_addra/o_addrb PE RAM port addresses
//   o_wea/o_web     PE RAM port write enables
//   o_alu_sel       ALU select to the PEs
//   o_count         bit-serial step counter
//   o_east/o_west/o_south/o_north  neighbour shift strobes
//   o_busy          instruction in progress
//   o_done          one-cycle pulse on instruction completion
//   o_ins_count     completed instruction counter, wraps
// ---------------------------------------------------------------------------
module pe_op_sequencer #(
  parameter int ALU_CYCLES = 67,  // count runs 0..ALU_CYCLES-1, at most 127
  parameter int ADDR_W     = 10,
  parameter int SEL_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ins_valid,
  output logic              o_ins_ready,
  input  logic [1:0]        i_ins_kind,
  input  logic [SEL_W-1:0]  i_ins_alu_sel,
  input  logic [1:0]        i_ins_dir,
  input  logic [ADDR_W-1:0] i_ins_src_a,
  input  logic [ADDR_W-1:0] i_ins_src_b,
  input  logic [ADDR_W-1:0] i_ins_dst,
`ifdef OP_EARLY_EXIT_EN
  input  logic              i_op_all,
  output logic              o_early_exit,
`endif
  output logic [ADDR_W-1:0] o_addra,
  output logic [ADDR_W-1:0] o_addrb,
  output logic              o_wea,
  output logic              o_web,
  output logic [SEL_W-1:0]  o_alu_sel,
  output logic [6:0]        o_count,
  output logic              o_east,
  output logic              o_west,
  output logic              o_south,
  output logic              o_north,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_ins_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALU_RUN = 3'd1,
    S_ALU_WB  = 3'd2,
    S_SH_RD   = 3'd3,
    S_SH_WR   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [6:0] LP_LAST = 7'(ALU_CYCLES - 1);

  // State and latched instruction fields
  state_t            r_state;
  logic [ADDR_W-1:0] r_src_a;
  logic [ADDR_W-1:0] r_src_b;
  logic [ADDR_W-1:0] r_dst;
  logic [SEL_W-1:0]  r_sel;
  logic [1:0]        r_dir;

  // Output registers
  logic              r_ins_ready;
  logic [ADDR_W-1:0] r_addra;
  logic [ADDR_W-1:0] r_addrb;
  logic              r_wea;
  logic              r_web;
  logic [SEL_W-1:0]  r_alu_sel;
  logic [6:0]        r_count;
  logic              r_east;
  logic              r_west;
  logic              r_south;
  logic              r_north;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_ins_count;

  // Next-state / next-output values
  state_t            w_next_state;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_src_a;
  logic [ADDR_W-1:0] w_src_b;
  logic [SEL_W-1:0]  w_sel;
  logic              w_ins_ready;
  logic [ADDR_W-1:0] w_addra;
  logic [ADDR_W-1:0] w_addrb;
  logic              w_wea;
  logic              w_web;
  logic [SEL_W-1:0]  w_alu_sel;
  logic [6:0]        w_count;
  logic              w_east;
  logic              w_west;
  logic              w_south;
  logic              w_north;
  logic              w_busy;
  logic              w_done;
  logic [15:0]       w_ins_count;

`ifdef OP_EARLY_EXIT_EN
  logic r_early_seen;
  logic w_early_exit;
`endif

  // o_ins_ready is only ever high in IDLE, so the registered ready alone
  // qualifies a transfer.
  assign w_xfer = i_ins_valid && r_ins_ready;

  // On the transfer edge the latched fields are not yet loaded, so the
  // first-cycle outputs of ALU_RUN and SH_RD take the fields straight from
  // the inputs. ALU_WB and SH_WR are never entered from IDLE and use the
  // latched copies directly.
  assign w_src_a = w_xfer ? i_ins_src_a   : r_src_a;
  assign w_src_b = w_xfer ? i_ins_src_b   : r_src_b;
  assign w_sel   = w_xfer ? i_ins_alu_sel : r_sel;

  // Next-state decision followed by the output values that belong to the
  // state being entered. Every output gets a zero default so states only
  // list what they drive.
  always_comb begin
    w_next_state = r_state;
`ifdef OP_EARLY_EXIT_EN
    w_early_exit = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          case (i_ins_kind)
            2'd0:    w_next_state = S_ALU_RUN;
            2'd1:    w_next_state = S_SH_RD;
            default: w_next_state = S_DONE;
          endcase
        end
      end
      S_ALU_RUN: begin
        if (r_count == LP_LAST) begin
          w_next_state = S_ALU_WB;
`ifdef OP_EARLY_EXIT_EN
        end else if (i_op_all && (r_count >= 7'd2)) begin
          w_next_state = S_ALU_WB;
          w_early_exit = 1'b1;
`endif
        end
      end
      S_ALU_WB: w_next_state = S_DONE;
      S_SH_RD:  w_next_state = S_SH_WR;
      S_SH_WR:  w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase

    w_ins_ready = 1'b0;
    w_addra     = '0;
    w_addrb     = '0;
    w_wea       = 1'b0;
    w_web       = 1'b0;
    w_alu_sel   = '0;
    w_count     = '0;
    w_east      = 1'b0;
    w_west      = 1'b0;
    w_south     = 1'b0;
    w_north     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_ins_count = r_ins_count;

    case (w_next_state)
      S_IDLE: begin
        w_ins_ready = 1'b1;
      end
      S_ALU_RUN: begin
        w_busy    = 1'b1;
        w_addra   = w_src_a;
        w_addrb   = w_src_b;
        w_alu_sel = w_sel;
        // Entering from IDLE starts the count at 0; otherwise it steps.
        w_count   = (r_state == S_ALU_RUN) ? (r_count + 7'd1) : 7'd0;
      end
      S_ALU_WB: begin
        // The count freezes at whatever value ended the ALU phase.
        w_busy    = 1'b1;
        w_addra   = r_dst;
        w_addrb   = r_src_b;
        w_wea     = 1'b1;
        w_alu_sel = r_sel;
        w_count   = r_count;
      end
      S_SH_RD: begin
        w_busy  = 1'b1;
        w_addra = w_src_a;
        w_addrb = w_src_b;
      end
      S_SH_WR: begin
        // Port B writes the word above the destination, wrapping at the top.
        w_busy  = 1'b1;
        w_addra = r_dst;
        w_addrb = r_dst + ADDR_W'(1);
        w_wea   = 1'b1;
        w_web   = 1'b1;
        case (r_dir)
          2'd0:    w_east  = 1'b1;
          2'd1:    w_west  = 1'b1;
          2'd2:    w_south = 1'b1;
          default: w_north = 1'b1;
        endcase
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_ins_count = r_ins_count + 16'd1;
      end
      default: begin
        w_ins_ready = 1'b0;
      end
    endcase
  end

  // State register and output flops. Reset clears everything at once, so an
  // aborted instruction leaves no enable or strobe high and is never counted.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_ins_ready <= 1'b0;
      r_addra     <= '0;
      r_addrb     <= '0;
      r_wea       <= 1'b0;
      r_web       <= 1'b0;
      r_alu_sel   <= '0;
      r_count     <= '0;
      r_east      <= 1'b0;
      r_west      <= 1'b0;
      r_south     <= 1'b0;
      r_north     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ins_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_ins_ready <= w_ins_ready;
      r_addra     <= w_addra;
      r_addrb     <= w_addrb;
      r_wea       <= w_wea;
      r_web       <= w_web;
      r_alu_sel   <= w_alu_sel;
      r_count     <= w_count;
      r_east      <= w_east;
      r_west      <= w_west;
      r_south     <= w_south;
      r_north     <= w_north;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_ins_count <= w_ins_count;
    end
  end

  // Instruction fields are captured once at the transfer edge and held for
  // the rest of the instruction. The kind is not kept: the state encodes it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_sel   <= '0;
      r_dir   <= '0;
    end else if (w_xfer) begin
      r_src_a <= i_ins_src_a;
      r_src_b <= i_ins_src_b;
      r_dst   <= i_ins_dst;
      r_sel   <= i_ins_alu_sel;
      r_dir   <= i_ins_dir;
    end
  end

`ifdef OP_EARLY_EXIT_EN
  // Sticky record that some ALU phase ended early; only reset clears it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_early_seen <= 1'b0;
    end else if (w_early_exit) begin
      r_early_seen <= 1'b1;
    end
  end

  assign o_early_exit = r_early_seen;
`endif

  assign o_ins_ready = r_ins_ready;
  assign o_addra     = r_addra;
  assign o_addrb     = r_addrb;
  assign o_wea       = r_wea;
  assign o_web       = r_web;
  assign o_alu_sel   = r_alu_sel;
  assign o_count     = r_count;
  assign o_east      = r_east;
  assign o_west      = r_west;
  assign o_south     = r_south;
  assign o_north     = r_north;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ins_count = r_ins_count;

endmodule
